// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: md_op encoding and op classification.
// The MDU_MADD_EN macro enables the multiply-accumulate opcodes.
package mdu_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MD datapath: 64-bit {hi,lo} result for the current op plus a divide-by-zero flag.
// With MDU_MADD_EN defined the accumulate/subtract variants use the incoming hi/lo.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs,
    input  logic [31:0]        rt,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [63:0]        result,
    output logic               div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_rt;
    logic               div_ovf;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // The divisor is forced to 1 for rt==0 and for 0x80000000/-1: the first keeps the
    // divider defined (result is discarded), the second yields exactly lo=0x80000000, hi=0.
    assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    assign div_rt  = ((rt == 32'd0) || div_ovf) ? 32'd1 : rt;

    assign quo_s = $signed(rs) / $signed(div_rt);
    assign rem_s = $signed(rs) % $signed(div_rt);
    assign quo_u = rs / div_rt;
    assign rem_u = rs % div_rt;

    assign div_zero = md_is_div(op) && (rt == 32'd0);

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi, lo};
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
            MD_MADD:  result = acc + prod_s;
            MD_MADDU: result = acc + prod_u;
            MD_MSUB:  result = acc - prod_s;
            MD_MSUBU: result = acc - prod_u;
`endif
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, models mult/div latency with a countdown, requests stalls.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU with multiply latency.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic               busy,
    output logic               stall_req,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;
    logic [63:0]      arith_res;
    logic             arith_dz;
    logic             start;

    mdu_arith u_arith (
        .op       (md_op),
        .rs       (rs_data),
        .rt       (rt_data),
        .hi       (hi),
        .lo       (lo),
        .result   (arith_res),
        .div_zero (arith_dz)
    );

    assign start     = md_is_start(md_op);
    assign busy      = (state == ST_RUN);
    assign stall_req = busy | start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi <= arith_res[63:32];
                        pend_lo <= arith_res[31:0];
                        // A zero divisor still occupies the unit but leaves HI/LO untouched.
                        pend_wr <= !arith_dz;
                        counter <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                        state   <= ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi <= rs_data;
                    end else if (md_op == MD_MTLO) begin
                        lo <= rs_data;
                    end
                end
                ST_RUN: begin
                    if (counter == CNT_W'(1)) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        counter <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed cases plus random ops against a 64-bit arithmetic model.
module tb_ex_mdu;
    import mdu_pkg::*;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mhi, mlo;

    ex_mdu #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_start(input logic [3:0] op);
        bit s;
        s = (op >= 4'd1 && op <= 4'd4);
`ifdef MDU_MADD_EN
        s = s || (op >= 4'd7 && op <= 4'd10);
`endif
        return s;
    endfunction

    function automatic int tb_latency(input logic [3:0] op);
        if (!tb_start(op)) return 0;
        return (op == 4'd3 || op == 4'd4) ? DIVN : MULN;
    endfunction

    // Architectural result of op applied to {h,l}, using plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, acc, uq, ur, t;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {h, l};
        case (op)
            4'd1: begin t = sa * sb; return t; end
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return acc;
                sq = sa / sb;
                sr = sa % sb;
                t = {sr[31:0], sq[31:0]};
                return t;
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            4'd5: return {a, l};
            4'd6: return {h, a};
`ifdef MDU_MADD_EN
            4'd7:  begin t = sa * sb; return acc + t; end
            4'd8:  return acc + ua * ub;
            4'd9:  begin t = sa * sb; return acc - t; end
            4'd10: return acc - ua * ub;
`endif
            default: return acc;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          cnt;
        exp = model(op, a, b, mhi, mlo);
        md_op = op; rs_data = a; rt_data = b;
        #1;
        check({tag, " stall_req"}, 32'(stall_req), 32'(tb_start(op)));
        tick();
        md_op = MD_NONE; rs_data = $urandom; rt_data = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            check({tag, " hi held"}, hi, mhi);
            check({tag, " lo held"}, lo, mlo);
            cnt++;
            tick();
        end
        check({tag, " busy cycles"}, 32'(cnt), 32'(tb_latency(op)));
        mhi = exp[63:32];
        mlo = exp[31:0];
        check({tag, " hi"}, hi, mhi);
        check({tag, " lo"}, lo, mlo);
    endtask

    initial begin
        int          cnt;
        logic [3:0]  ops [6];
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; md_op = MD_NONE; rs_data = 32'd0; rt_data = 32'd0;
        tick(); tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall_req", 32'(stall_req), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        tick();

        run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult -2*3 hi const", hi, 32'hFFFF_FFFF);
        check("mult -2*3 lo const", lo, 32'hFFFF_FFFA);
        run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu hi const", hi, 32'hFFFF_FFFE);
        check("multu lo const", lo, 32'h0000_0001);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div lo const", lo, 32'hFFFF_FFFD);
        check("div hi const", hi, 32'hFFFF_FFFF);
        run_op("divu by 0", MD_DIVU, 32'hFFFF_FFF9, 32'd0);
        check("divu0 hi const", hi, 32'hFFFF_FFFF);
        check("divu0 lo const", lo, 32'hFFFF_FFFD);
        run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div ovf lo const", lo, 32'h8000_0000);
        check("div ovf hi const", hi, 32'd0);

        // MTHI and a second MULT issued while busy must both be ignored.
        run_op("mtlo zero", MD_MTLO, 32'd0, 32'd0);
        md_op = MD_MULT; rs_data = 32'd7; rt_data = 32'd9;
        tick();
        md_op = MD_MTHI; rs_data = 32'h1234_5678;
        #1;
        check("busy mthi stall_req", 32'(stall_req), 32'd1);
        tick();
        check("busy mthi ignored", hi, 32'd0);
        md_op = MD_MULT; rs_data = 32'd5; rt_data = 32'd5;
        #1;
        check("busy mult stall_req", 32'(stall_req), 32'd1);
        tick();
        md_op = MD_NONE;
        cnt = 2;
        while (busy === 1'b1 && cnt < 100) begin
            check("busy window stall_req", 32'(stall_req), 32'd1);
            cnt++;
            tick();
        end
        check("overlap busy cycles", 32'(cnt), 32'(MULN));
        check("overlap hi", hi, 32'd0);
        check("overlap lo", lo, 32'd63);
        mhi = 32'd0; mlo = 32'd63;
        run_op("mthi idle", MD_MTHI, 32'h1234_5678, 32'd0);
        check("mthi idle const", hi, 32'h1234_5678);

        // Accumulate: effective only when the multiply-accumulate opcodes are built in.
        run_op("acc mthi", MD_MTHI, 32'd0, 32'd0);
        run_op("acc mtlo", MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu 1*1", MD_MADDU, 32'd1, 32'd1);
        run_op("unknown op", 4'd13, 32'hDEAD_BEEF, 32'd3);

        ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV;
        ops[3] = MD_DIVU; ops[4] = MD_MTHI;  ops[5] = MD_MTLO;
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 5)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op("random", op, a, b);
        end

        // Reset mid-DIV once the counter has reached 6.
        run_op("pre-reset mthi", MD_MTHI, 32'hA5A5_A5A5, 32'd0);
        md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        md_op = MD_NONE;
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        for (int i = 0; i < DIVN; i++) tick();
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset hi", hi, 32'd0);
        check("post-reset lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MD operation plus the rs/rt operand values (after forwarding) and owns the architectural HI/LO registers.
- Models multi-cycle mult/div latency with a countdown counter.
- Drives a busy/stall request to the hazard unit so that dependent MD instructions freeze in ID.

Parameters:
- MUL_CYCLES, 5, busy duration in cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (>=1)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- md_op  input  4  MD operation code of the instruction currently in EX (package encoding)
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- busy  output  1  a mult/div is in flight
- stall_req  output  1  busy OR (md_op is a mult/div start); consumed by the hazard unit
- hi  output  32  architectural HI register (mfhi source)
- lo  output  32  architectural LO register (mflo source)

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, pending result=0. Applies immediately, including mid-operation; any in-flight result is discarded.
- Start acceptance: a start is accepted at posedge when busy=0 and md_op is MULT, MULTU, DIV or DIVU.
  - At acceptance: compute the 64-bit result into pending_hi/pending_lo; load counter with MUL_CYCLES or DIV_CYCLES; set busy=1.
- Countdown: while busy, counter decrements by 1 each cycle.
  - At the edge where counter==1: hi/lo take the pending values, busy drops to 0, counter goes to 0.
  - busy is therefore high for exactly N cycles, starting the cycle after acceptance.
  - hi/lo hold their old values for the entire busy window.
- States: IDLE (busy=0) and RUN (busy=1). IDLE->RUN on accepted start; RUN->IDLE when counter==1.
- Arithmetic rules:
  - MULT: signed 32x32 to 64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: unsigned 32x32 to 64, same hi/lo split.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder carrying the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divisor 0: operation is accepted and the busy window runs, but hi/lo stay unchanged at completion.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: when busy=0, hi (resp. lo) <= rs_data at the next edge. When busy=1 the write is ignored (the hazard unit must have stalled it).
- Any MD start while busy=1 is ignored; no queueing.
- stall_req is combinational: busy | (md_op in {MULT, MULTU, DIV, DIVU}). Also asserted on the acceptance cycle.
- MFHI/MFLO need no action in this block; EX muxes hi/lo directly. Reads during busy are prevented by the hazard unit via stall_req.
- MD_NONE and unknown codes: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD/MADDU/MSUB/MSUBU codes.
  - Start and latency follow MULT_CYCLES.
  - Pending result = {hi,lo} ± product, with the signedness of the opcode variant.
  - {hi,lo} is sampled at acceptance.
- Undefined: these codes behave as MD_NONE; no accumulator logic is synthesized.

Decomposition:
- Shared package mdu_pkg:
  - md_op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - A constant for the width of md_op.
- One combinational sub-module, mdu_arith: takes op, rs, rt, hi, lo and returns the 64-bit result plus a div-by-zero flag.
- Counter and HI/LO registers live in ex_mdu.

Test Plan:
- Reset asserted mid-DIV (counter=6) -> busy, hi and lo go to 0 immediately, without waiting for a clock edge.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo hold prior values during busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same test with DIVU rt=0 -> hi/lo unchanged.
- MTHI rs=0x12345678 while busy -> ignored. Same MTHI while idle -> hi=0x12345678 next cycle. A second MULT issued during busy is ignored; stall_req stays high throughout.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU rs=1, rt=1 -> after 5 cycles hi=1, lo=0.
